lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 34 +++
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundles the CPU-side request/response signals and the
// data-memory strobe/address/data signals of the load/store controller.
//   slave  : seen by lsu_ctrl (takes CPU requests, drives memory strobes)
//   master : seen by the CPU/memory environment around the controller
interface lsu_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_done, cpu_err, cpu_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_done, cpu_err, cpu_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RISC-V style load/store unit controller in front of a
// word-wide data memory with combinational reads. Sub-word stores are done
// as read-modify-write; loads are lane-selected and sign/zero extended.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lsu_ctrl_if.slave (CPU request/response + memory strobes)
//
// state  | meaning
// S_IDLE | ready, waiting for cpu_req
// S_RD   | memory word read (load, or first half of sb/sh)
// S_WR   | memory word write (sw, or second half of sb/sh)
// S_DONE | completion pulse, no error
// S_ERR  | completion pulse with error, no memory access made
module lsu_ctrl #(
  parameter int AW = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_we;
  logic [2:0]     r_funct3;
  logic [AW-1:0]  r_addr;
  logic [31:0]    r_wdata;
  logic [31:0]    r_word;
  logic [31:0]    r_rdata;
  logic           w_accept;
  logic           w_illegal;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [31:0]    w_load;
  logic [31:0]    w_merge;

  assign w_accept = (r_state == S_IDLE) && bus.cpu_req;

  // Stores only support b/h/w; loads additionally bu/hu.
  always_comb begin
    w_illegal = 1'b0;
    case (bus.cpu_funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = bus.cpu_addr[0];
      3'b010:  w_illegal = |bus.cpu_addr[1:0];
      3'b100:  w_illegal = bus.cpu_we;
      3'b101:  w_illegal = bus.cpu_we | bus.cpu_addr[0];
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_req) begin
          if (w_illegal)                         w_next = S_ERR;
          else if (!bus.cpu_we)                  w_next = S_RD;
          else if (bus.cpu_funct3 == 3'b010)     w_next = S_WR;
          else                                   w_next = S_RD;
        end
      end
      S_RD:    w_next = r_we ? S_WR : S_DONE;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_word   <= 32'h0;
      r_rdata  <= 32'h0;
    end else begin
      if (w_accept) begin
        r_we     <= bus.cpu_we;
        r_funct3 <= bus.cpu_funct3;
        r_addr   <= bus.cpu_addr[AW-1:0];
        r_wdata  <= bus.cpu_wdata;
      end
      if (r_state == S_RD) begin
        r_word <= bus.mem_rd_data;
        if (!r_we) r_rdata <= w_load;
      end
    end
  end

  // Load lane select and extension straight off the memory read data.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = bus.mem_rd_data[7:0];
      2'd1:    w_byte = bus.mem_rd_data[15:8];
      2'd2:    w_byte = bus.mem_rd_data[23:16];
      default: w_byte = bus.mem_rd_data[31:24];
    endcase
    w_half = r_addr[1] ? bus.mem_rd_data[31:16] : bus.mem_rd_data[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = bus.mem_rd_data;
    endcase
  end

  // Store word: sw writes wdata as is, sb/sh patch one lane of the word read in S_RD.
  always_comb begin
    w_merge = r_word;
    case (r_funct3[1:0])
      2'b00: begin
        case (r_addr[1:0])
          2'd0:    w_merge[7:0]   = r_wdata[7:0];
          2'd1:    w_merge[15:8]  = r_wdata[7:0];
          2'd2:    w_merge[23:16] = r_wdata[7:0];
          default: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  assign bus.cpu_ready   = (r_state == S_IDLE);
  assign bus.cpu_done    = (r_state == S_DONE) || (r_state == S_ERR);
  assign bus.cpu_err     = (r_state == S_ERR);
  assign bus.cpu_rdata   = r_rdata;
  assign bus.mem_rd      = (r_state == S_RD);
  assign bus.mem_wr      = (r_state == S_WR);
  assign bus.mem_addr    = {{(32-AW){1'b0}}, r_addr[AW-1:2], 2'b00};
  assign bus.mem_wr_data = w_merge;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errs;
  int   cyc;
  int   wr_count;
  int   both_viol;
  int   n_rd;
  int   n_wr;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.AW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign bus.mem_rd_data = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_wr) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wr_data;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] maddr;
    int          t0;
  } sb_t;

  sb_t sb_q[$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Expected latency and strobe counts follow from the kind of access.
  function automatic sb_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic err, input logic [31:0] rdata, input int t0);
    sb_t e;
    e.err   = err;
    e.rdata = rdata;
    e.maddr = addr & 32'h0000_03FC;
    e.t0    = t0;
    if (err)               begin e.lat = 1; e.nrd = 0; e.nwr = 0; end
    else if (!we)          begin e.lat = 2; e.nrd = 1; e.nwr = 0; end
    else if (f3 == 3'b010) begin e.lat = 2; e.nrd = 0; e.nwr = 1; end
    else                   begin e.lat = 3; e.nrd = 1; e.nwr = 1; end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      n_rd = 0;
      n_wr = 0;
    end else begin
      if (bus.mem_rd && bus.mem_wr) both_viol++;
      if (bus.mem_rd) n_rd++;
      if (bus.mem_wr) n_wr++;
      if ((bus.mem_rd || bus.mem_wr) && sb_q.size() > 0)
        chk("mem_addr", bus.mem_addr, sb_q[0].maddr);
      if (bus.cpu_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("cpu_err", {31'd0, bus.cpu_err}, {31'd0, e.err});
          chk("cpu_rdata", bus.cpu_rdata, e.rdata);
          chk("latency", cyc - e.t0, e.lat);
          chk("n_mem_rd", n_rd, e.nrd);
          chk("n_mem_wr", n_wr, e.nwr);
        end
        n_rd = 0;
        n_wr = 0;
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.cpu_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.cpu_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
    wait_ready();
    sb_q.push_back(mk(we, f3, addr, err, rdata, cyc));
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = we;
    bus.cpu_funct3 = f3;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wdata;
    @(negedge clk);
    bus.cpu_req    = 1'b0;
    wait_drain();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int wc0;
    checks = 0; errs = 0; cyc = 0; wr_count = 0; both_viol = 0; n_rd = 0; n_wr = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'h11223344;
    mem[17] = 32'h8899AABB;
    mem[18] = 32'hCAFEF00D;

    vecs[0]  = '{1'b0, 3'b000, 32'h43, 32'h0,        1'b0, 32'h00000011};
    vecs[1]  = '{1'b0, 3'b000, 32'h40, 32'h0,        1'b0, 32'h00000044};
    vecs[2]  = '{1'b0, 3'b001, 32'h46, 32'h0,        1'b0, 32'hFFFF8899};
    vecs[3]  = '{1'b0, 3'b101, 32'h46, 32'h0,        1'b0, 32'h00008899};
    vecs[4]  = '{1'b0, 3'b100, 32'h44, 32'h0,        1'b0, 32'h000000BB};
    vecs[5]  = '{1'b0, 3'b000, 32'h44, 32'h0,        1'b0, 32'hFFFFFFBB};
    vecs[6]  = '{1'b0, 3'b001, 32'h44, 32'h0,        1'b0, 32'hFFFFAABB};
    vecs[7]  = '{1'b0, 3'b010, 32'h48, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 3'b000, 32'h41, 32'h000000A5, 1'b0, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 3'b010, 32'h40, 32'h0,        1'b0, 32'h1122A544};
    vecs[10] = '{1'b0, 3'b010, 32'h42, 32'h0,        1'b1, 32'h1122A544};
    vecs[11] = '{1'b1, 3'b011, 32'h40, 32'h12345678, 1'b1, 32'h1122A544};
    vecs[12] = '{1'b1, 3'b001, 32'h42, 32'h1234BEEF, 1'b0, 32'h1122A544};
    vecs[13] = '{1'b0, 3'b010, 32'h40, 32'h0,        1'b0, 32'hBEEFA544};
    vecs[14] = '{1'b1, 3'b010, 32'h48, 32'hDEADBEEF, 1'b0, 32'hBEEFA544};
    vecs[15] = '{1'b0, 3'b010, 32'h48, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[16] = '{1'b0, 3'b101, 32'h41, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[17] = '{1'b0, 3'b011, 32'h40, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[18] = '{1'b0, 3'b100, 32'h4B, 32'h0,        1'b0, 32'h000000DE};
    vecs[19] = '{1'b1, 3'b001, 32'h41, 32'h0000FFFF, 1'b1, 32'h000000DE};

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b000;
    bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready",   {31'd0, bus.cpu_ready}, 32'd1);
    chk("rst_done",    {31'd0, bus.cpu_done},  32'd0);
    chk("rst_err",     {31'd0, bus.cpu_err},   32'd0);
    chk("rst_mem_rd",  {31'd0, bus.mem_rd},    32'd0);
    chk("rst_mem_wr",  {31'd0, bus.mem_wr},    32'd0);
    chk("rst_maddr",   bus.mem_addr,           32'h0);
    chk("rst_wdata",   bus.mem_wr_data,        32'h0);
    chk("rst_rdata",   bus.cpu_rdata,          32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++)
      do_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);

    // Back-to-back stores with cpu_req held high throughout.
    wait_ready();
    wc0 = wr_count;
    t1  = cyc;
    sb_q.push_back(mk(1'b1, 3'b010, 32'h80, 1'b0, 32'h000000DE, t1));
    sb_q.push_back(mk(1'b1, 3'b010, 32'h84, 1'b0, 32'h000000DE, t1 + 3));
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_funct3 = 3'b010;
    bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'h11111111;
    @(negedge clk);
    bus.cpu_addr = 32'h84; bus.cpu_wdata = 32'h22222222;
    repeat (3) @(negedge clk);
    bus.cpu_req = 1'b0;
    wait_drain();
    @(negedge clk);
    chk("b2b_wr_count", wr_count - wc0, 32'd2);

    // Reset during the read half of an sh.
    wait_ready();
    wc0 = wr_count;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_funct3 = 3'b001;
    bus.cpu_addr = 32'h44; bus.cpu_wdata = 32'h0000BEEF;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    chk("rd_rst_in_rd", {31'd0, bus.mem_rd}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rd_rst_ready", {31'd0, bus.cpu_ready}, 32'd1);
    chk("rd_rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rd_rst_rdata", bus.cpu_rdata, 32'h0);
    chk("rd_rst_maddr", bus.mem_addr, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rd_rst_no_write", wr_count - wc0, 32'd0);
    chk("rd_rst_mem44", mem[17], 32'h8899AABB);

    // Reset during the write cycle of an sw.
    wait_ready();
    wc0 = wr_count;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_funct3 = 3'b010;
    bus.cpu_addr = 32'h88; bus.cpu_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    chk("wr_rst_in_wr", {31'd0, bus.mem_wr}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("wr_rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("wr_rst_no_write", wr_count - wc0, 32'd0);
    chk("wr_rst_mem88", mem[34], 32'h0);

    do_op(1'b0, 3'b010, 32'h80, 32'h0, 1'b0, 32'h11111111);
    do_op(1'b0, 3'b101, 32'h86, 32'h0, 1'b0, 32'h00002222);
    do_op(1'b0, 3'b010, 32'h88, 32'h0, 1'b0, 32'h00000000);

    chk("mem40", mem[16], 32'hBEEFA544);
    chk("mem44", mem[17], 32'h8899AABB);
    chk("mem48", mem[18], 32'hDEADBEEF);
    chk("mem80", mem[32], 32'h11111111);
    chk("mem84", mem[33], 32'h22222222);
    chk("rd_wr_overlap", both_viol, 32'd0);
    chk("sb_leftover", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
